cp0_regs: RTL and testbench

Coprocessor-0 register file for the MIPS core. It holds Status, Cause, EPC, BadVAddr, Count and Compare, and runs the Count/Compare timer interrupt. It consumes the exception unit's registered commit outputs: `wr_exp`, `exp_code`, `epc`, `badvaddr(_we)` and `clear_exl`. It feeds back `epc_out`, `allow_int` and `interrupt_flag` to the exception unit, and serves MFC0/MTC0 from the pipeline.

---
 rtl/cp0_regs_if.sv | 52 +++++
 rtl/cp0_regs.sv | 159 +++++++++++++++
 tb/tb_cp0_regs.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cp0_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : cp0_regs_if
// Description : Bus bundle between the pipeline/exception unit and the CP0
//               register file. Carries the MFC0 read port, the MTC0 write
//               port, the external interrupt lines, the exception commit
//               strobes and the register/interrupt status returned to the
//               core.
//               slave  : the CP0 register file side
//               master : the core (pipeline + exception unit) side
// Revision    : 1.0  initial release
// ============================================================================
interface cp0_regs_if;
    // MFC0 read port
    logic [4:0]  raddr;
    logic [31:0] rdata;
    // MTC0 write port
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    // external interrupt lines (level-sensitive)
    logic [5:0]  hw_int;
    // exception unit commit outputs
    logic        wr_exp;
    logic [4:0]  exp_code;
    logic [31:0] epc;
    logic        in_delayslot;
    logic        badvaddr_we;
    logic [31:0] badvaddr;
    logic        clear_exl;
    // state returned to the core
    logic [31:0] epc_out;
    logic        allow_int;
    logic [7:0]  interrupt_flag;
    logic [31:0] status;
    logic [31:0] cause;

    modport slave (
        input  raddr, we, waddr, wdata, hw_int,
        input  wr_exp, exp_code, epc, in_delayslot,
        input  badvaddr_we, badvaddr, clear_exl,
        output rdata, epc_out, allow_int, interrupt_flag, status, cause
    );

    modport master (
        output raddr, we, waddr, wdata, hw_int,
        output wr_exp, exp_code, epc, in_delayslot,
        output badvaddr_we, badvaddr, clear_exl,
        input  rdata, epc_out, allow_int, interrupt_flag, status, cause
    );
endinterface
`default_nettype wire

// File: rtl/cp0_regs.sv
`default_nettype none
// ============================================================================
// Module      : cp0_regs
// Description : MIPS coprocessor-0 register file: Status, Cause, EPC,
//               BadVAddr, Count and Compare, plus the Count/Compare timer
//               interrupt.
// Ports       : clk   - core clock, rising edge
//               reset - asynchronous active-high reset
//               bus   - cp0_regs_if.slave (MFC0/MTC0 ports, hw_int,
//                       exception commit strobes, EPC/Status/Cause and
//                       interrupt status outputs)
// Revision    : 1.0  initial release
// ============================================================================
module cp0_regs (
    input  logic        clk,
    input  logic        reset,
    cp0_regs_if.slave   bus
);

    localparam logic [4:0] c_REG_BADVADDR = 5'd8;
    localparam logic [4:0] c_REG_COUNT    = 5'd9;
    localparam logic [4:0] c_REG_COMPARE  = 5'd11;
    localparam logic [4:0] c_REG_STATUS   = 5'd12;
    localparam logic [4:0] c_REG_CAUSE    = 5'd13;
    localparam logic [4:0] c_REG_EPC      = 5'd14;

    // Status fields
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    // Cause fields
    logic        r_bd;
    logic        r_ti;
    logic [5:0]  r_ip_hw;     // IP[7:2], sampled from hw_int every cycle
    logic [1:0]  r_ip_sw;     // IP[1:0], software interrupts
    logic [4:0]  r_exccode;
    // full-width registers
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_tick;      // divides the core clock by two for Count

    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic [31:0] w_epc_next;

    assign w_wr_count   = bus.we && (bus.waddr == c_REG_COUNT);
    assign w_wr_compare = bus.we && (bus.waddr == c_REG_COMPARE);
    assign w_wr_status  = bus.we && (bus.waddr == c_REG_STATUS);
    assign w_wr_cause   = bus.we && (bus.waddr == c_REG_CAUSE);
    assign w_wr_epc     = bus.we && (bus.waddr == c_REG_EPC);

    // BEV (bit 22) is hard-wired to 1.
    assign w_status = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
    assign w_cause  = {r_bd, r_ti, 14'd0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b00};

    // A delay-slot fault restarts at the branch, one word earlier.
    assign w_epc_next = bus.in_delayslot ? (bus.epc - 32'd4) : bus.epc;

    assign bus.status         = w_status;
    assign bus.cause          = w_cause;
    assign bus.epc_out        = r_epc;
    assign bus.allow_int      = r_ie & ~r_exl;
    assign bus.interrupt_flag = w_cause[15:8] & w_status[15:8];

    always_comb begin
        bus.rdata = 32'd0;
        case (bus.raddr)
            c_REG_BADVADDR: bus.rdata = r_badvaddr;
            c_REG_COUNT:    bus.rdata = r_count;
            c_REG_COMPARE:  bus.rdata = r_compare;
            c_REG_STATUS:   bus.rdata = w_status;
            c_REG_CAUSE:    bus.rdata = w_cause;
            c_REG_EPC:      bus.rdata = r_epc;
            default:        bus.rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_im       <= 8'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ti       <= 1'b0;
            r_ip_hw    <= 6'd0;
            r_ip_sw    <= 2'd0;
            r_exccode  <= 5'd0;
            r_epc      <= 32'd0;
            r_badvaddr <= 32'd0;
            r_count    <= 32'd0;
            r_compare  <= 32'd0;
            r_tick     <= 1'b0;
        end else begin
            // Count advances on every other cycle; a write realigns the phase.
            if (w_wr_count) begin
                r_count <= bus.wdata;
                r_tick  <= 1'b0;
            end else begin
                r_tick <= ~r_tick;
                if (r_tick) begin
                    r_count <= r_count + 32'd1;
                end
            end

            // TI is sticky until software rewrites Compare.
            if (w_wr_compare) begin
                r_compare <= bus.wdata;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end

            // Timer interrupt shares IP7 with hw_int[5].
            r_ip_hw <= {bus.hw_int[5] | r_ti, bus.hw_int[4:0]};

            if (w_wr_status) begin
                r_im <= bus.wdata[15:8];
                r_ie <= bus.wdata[0];
            end

            // Exception entry beats ERET, and both beat an MTC0 to EXL.
            if (bus.wr_exp) begin
                r_exl <= 1'b1;
            end else if (bus.clear_exl) begin
                r_exl <= 1'b0;
            end else if (w_wr_status) begin
                r_exl <= bus.wdata[1];
            end

            if (w_wr_cause) begin
                r_ip_sw <= bus.wdata[9:8];
            end

            // Nested exceptions keep the original EPC/BD.
            if (bus.wr_exp) begin
                r_exccode <= bus.exp_code;
                if (!r_exl) begin
                    r_epc <= w_epc_next;
                    r_bd  <= bus.in_delayslot;
                end
            end else if (w_wr_epc && !bus.clear_exl) begin
                r_epc <= bus.wdata;
            end

            if (bus.badvaddr_we) begin
                r_badvaddr <= bus.badvaddr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_regs
// Description : Directed self-checking bench for cp0_regs. Inputs change
//               1 ns after the rising edge; outputs are sampled there too.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cp0_regs;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    cp0_regs_if bus ();

    cp0_regs u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        bus.raddr = addr;
        #1;
        check(tag, bus.rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.we    = 1'b1;
        bus.waddr = addr;
        bus.wdata = data;
        step();
        bus.we    = 1'b0;
    endtask

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        reset            = 1'b0;
        bus.raddr        = 5'd0;
        bus.we           = 1'b0;
        bus.waddr        = 5'd0;
        bus.wdata        = 32'd0;
        bus.hw_int       = 6'd0;
        bus.wr_exp       = 1'b0;
        bus.exp_code     = 5'd0;
        bus.epc          = 32'd0;
        bus.in_delayslot = 1'b0;
        bus.badvaddr_we  = 1'b0;
        bus.badvaddr     = 32'd0;
        bus.clear_exl    = 1'b0;

        // Reset asserted mid-cycle, checked while still asserted
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_status", bus.status, 32'h0040_0000);
        check("rst_cause", bus.cause, 32'h0);
        check("rst_epc", bus.epc_out, 32'h0);
        check("rst_allow_int", {31'd0, bus.allow_int}, 32'h0);
        read_chk("rst_badvaddr", 5'd8, 32'h0);
        read_chk("rst_count", 5'd9, 32'h0);
        read_chk("rst_compare", 5'd11, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Status write, then hardware interrupt line 0
        mtc0(5'd12, 32'h0000_0401);
        check("st_allow_int", {31'd0, bus.allow_int}, 32'h1);
        check("st_status", bus.status, 32'h0040_0401);
        bus.hw_int = 6'b000001;
        step();
        check("hw_int_flag", {24'd0, bus.interrupt_flag}, 32'h04);
        bus.hw_int = 6'd0;
        step();
        check("hw_int_flag_off", {24'd0, bus.interrupt_flag}, 32'h00);

        // Delay-slot exception
        bus.wr_exp       = 1'b1;
        bus.epc          = 32'hBFC0_1008;
        bus.in_delayslot = 1'b1;
        bus.exp_code     = 5'h08;
        step();
        bus.wr_exp = 1'b0;
        check("ds_epc", bus.epc_out, 32'hBFC0_1004);
        check("ds_bd", {31'd0, bus.cause[31]}, 32'h1);
        check("ds_exccode", {27'd0, bus.cause[6:2]}, 32'h8);
        check("ds_exl", {31'd0, bus.status[1]}, 32'h1);
        check("ds_allow_int", {31'd0, bus.allow_int}, 32'h0);
        read_chk("ds_epc_rd", 5'd14, 32'hBFC0_1004);

        // Nested exception: EPC/BD held, ExcCode updated
        bus.wr_exp       = 1'b1;
        bus.epc          = 32'h1234_5678;
        bus.in_delayslot = 1'b0;
        bus.exp_code     = 5'h04;
        step();
        bus.wr_exp = 1'b0;
        check("nest_epc", bus.epc_out, 32'hBFC0_1004);
        check("nest_bd", {31'd0, bus.cause[31]}, 32'h1);
        check("nest_exccode", {27'd0, bus.cause[6:2]}, 32'h4);

        // ERET
        bus.clear_exl = 1'b1;
        step();
        bus.clear_exl = 1'b0;
        check("eret_exl", {31'd0, bus.status[1]}, 32'h0);
        check("eret_allow_int", {31'd0, bus.allow_int}, 32'h1);
        check("eret_epc", bus.epc_out, 32'hBFC0_1004);

        // wr_exp + clear_exl + MTC0 Status <- 0 in one cycle
        bus.wr_exp    = 1'b1;
        bus.clear_exl = 1'b1;
        bus.epc       = 32'h8000_0180;
        bus.exp_code  = 5'h0C;
        mtc0(5'd12, 32'h0);
        bus.wr_exp    = 1'b0;
        bus.clear_exl = 1'b0;
        check("sim_status", bus.status, 32'h0040_0002);
        check("sim_allow_int", {31'd0, bus.allow_int}, 32'h0);
        check("sim_epc", bus.epc_out, 32'h8000_0180);

        // Status write mask, Cause software IP, unmapped and BadVAddr
        mtc0(5'd12, 32'hFFFF_FFFF);
        check("st_mask", bus.status, 32'h0040_FF03);
        mtc0(5'd13, 32'hFFFF_FFFF);
        check("cause_sw_ip", {30'd0, bus.cause[9:8]}, 32'h3);
        check("cause_exccode_ro", {27'd0, bus.cause[6:2]}, 32'hC);
        mtc0(5'd13, 32'h0);
        bus.badvaddr_we = 1'b1;
        bus.badvaddr    = 32'hDEAD_BEEF;
        mtc0(5'd8, 32'h0);
        bus.badvaddr_we = 1'b0;
        read_chk("badvaddr", 5'd8, 32'hDEAD_BEEF);
        mtc0(5'd5, 32'h1234_5678);
        read_chk("unmapped_rd", 5'd5, 32'h0);

        // Count wraps
        mtc0(5'd9, 32'hFFFF_FFFF);
        step();
        read_chk("cnt_hold", 5'd9, 32'hFFFF_FFFF);
        step();
        read_chk("cnt_wrap", 5'd9, 32'h0);

        // Timer interrupt with IM7 only
        mtc0(5'd12, 32'h0000_8000);
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd5);
        for (int i = 0; i < 8; i++) step();
        read_chk("tmr_cnt4", 5'd9, 32'd4);
        check("tmr_ti_early", {31'd0, bus.cause[30]}, 32'h0);
        step();
        read_chk("tmr_cnt5", 5'd9, 32'd5);
        check("tmr_ti_pre", {31'd0, bus.cause[30]}, 32'h0);
        check("tmr_flag_pre", {24'd0, bus.interrupt_flag}, 32'h00);
        step();
        check("tmr_ti_set", {31'd0, bus.cause[30]}, 32'h1);
        step();
        check("tmr_flag7", {24'd0, bus.interrupt_flag}, 32'h80);
        mtc0(5'd11, 32'd100);
        check("tmr_ti_clr", {31'd0, bus.cause[30]}, 32'h0);
        read_chk("tmr_compare", 5'd11, 32'd100);

        // Reset in the middle of an exception
        bus.wr_exp = 1'b1;
        bus.epc    = 32'h0000_1000;
        step();
        bus.wr_exp = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst2_status", bus.status, 32'h0040_0000);
        check("rst2_cause", bus.cause, 32'h0);
        check("rst2_epc", bus.epc_out, 32'h0);
        check("rst2_flag", {24'd0, bus.interrupt_flag}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
